// File: rtl/fma_line_packer_pkg.sv
// Shared GPU definitions: default FMA result geometry and line derivation helpers.
package fma_line_packer_pkg;

  localparam int DEF_FMA_COUNT  = 2;
  localparam int DEF_WORD_WIDTH = 16;
  localparam int DEF_LINE_WIDTH = 96;

  // Words per packed memory line.
  function automatic int calc_wpl(input int line_w, input int word_w);
    return line_w / word_w;
  endfunction

  // FMA groups (one word from every lane) per packed memory line.
  function automatic int calc_gpl(input int line_w, input int word_w, input int fma_cnt);
    return (line_w / word_w) / fma_cnt;
  endfunction

endpackage

// File: rtl/fma_line_packer_line_fifo.sv
// Completed-line queue: ready/valid FIFO with a combinational head and
// push-while-full allowed when the head is popped in the same cycle.
module line_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       wr_valid_in,
  input  logic [WIDTH-1:0]           wr_data_in,
  output logic                       wr_ready_out,
  output logic                       wr_drop_out,
  output logic                       rd_valid_out,
  output logic [WIDTH-1:0]           rd_data_out,
  input  logic                       rd_ready_in,
  output logic [$clog2(DEPTH+1)-1:0] count_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop, push_ok, full;

  // Pointer and occupancy bookkeeping; a push into a full queue only lands
  // when the head leaves on the same edge.
  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    pop      = (count_q != '0) && rd_ready_in;
    push_ok  = wr_valid_in && (!full || pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state, cleared asynchronously so queued lines vanish on reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Line storage; contents are only visible through the gated head below.
  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_data_in;
    end
  end

  assign wr_ready_out = !full;
  assign wr_drop_out  = wr_valid_in && full && !pop;
  assign rd_valid_out = (count_q != '0);
  assign rd_data_out  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_out    = count_q;

endmodule

// File: rtl/fma_line_packer.sv
// Gathers per-lane FMA result words into groups, packs groups into memory
// lines (slot 0 in the MSBs) and queues finished or flushed lines.
module fma_line_packer
  import fma_line_packer_pkg::*;
#(
  parameter int FMA_COUNT  = DEF_FMA_COUNT,
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int LINE_WIDTH = DEF_LINE_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                                       clk_in,
  input  logic                                       rst_in,
  input  logic [FMA_COUNT*WORD_WIDTH-1:0]            fma_out_in,
  input  logic [FMA_COUNT-1:0]                       fma_valid_in,
  input  logic                                       flush_in,
  input  logic                                       clear_errors_in,
  output logic [LINE_WIDTH-1:0]                      line_out,
  output logic [$clog2(LINE_WIDTH/WORD_WIDTH):0]     line_words_out,
  output logic                                       line_valid_out,
  input  logic                                       line_ready_in,
  output logic                                       fma_ready_out,
  output logic [$clog2(DEPTH+1)-1:0]                 count_out,
  output logic                                       overflow_out,
  output logic                                       collision_out
);

  localparam int WPL    = calc_wpl(LINE_WIDTH, WORD_WIDTH);
  localparam int GPL    = calc_gpl(LINE_WIDTH, WORD_WIDTH, FMA_COUNT);
  localparam int LWW    = $clog2(WPL) + 1;
  localparam int GRP_W  = FMA_COUNT * WORD_WIDTH;
  localparam int SLOT_W = (GPL > 1) ? $clog2(GPL) : 1;

  if (((LINE_WIDTH % WORD_WIDTH) != 0) || ((WPL % FMA_COUNT) != 0)) begin : g_bad_geometry
    $error("fma_line_packer: line must hold a whole number of words and of FMA groups");
  end

  logic [FMA_COUNT-1:0]  hold_q, hold_d;
  logic [GRP_W-1:0]      hold_data_q, hold_data_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic                  flush_pend_q, flush_pend_d;
  logic [LINE_WIDTH-1:0] asm_q, asm_d;
  logic                  push_vld_q, push_vld_d;
  logic [LINE_WIDTH-1:0] push_line_q, push_line_d;
  logic [LWW-1:0]        push_words_q, push_words_d;
  logic                  collision_q, collision_d;
  logic                  overflow_q, overflow_d;
  logic [FMA_COUNT-1:0]  capture, clash;
  logic                  group_done;
  logic                  fifo_drop;
  logic [LWW+LINE_WIDTH-1:0] fifo_head;

  // Lane capture, group completion, slot assembly and flush; a finished or
  // flushed line is staged one cycle in push_* before entering the queue.
  always_comb begin
    capture     = fma_valid_in & ~hold_q;
    clash       = fma_valid_in & hold_q;
    hold_data_d = hold_data_q;
    for (int i = 0; i < FMA_COUNT; i++) begin
      if (capture[i]) begin
        hold_data_d[i*WORD_WIDTH +: WORD_WIDTH] = fma_out_in[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
    group_done   = &(hold_q | capture);
    hold_d       = group_done ? '0 : (hold_q | capture);
    slot_d       = slot_q;
    asm_d        = asm_q;
    push_vld_d   = 1'b0;
    push_line_d  = push_line_q;
    push_words_d = push_words_q;
    // A flush that meets a completing group waits one cycle.
    flush_pend_d = flush_pend_q | flush_in;
    if (group_done) begin
      asm_d[LINE_WIDTH-1 - int'(slot_q)*GRP_W -: GRP_W] = hold_data_d;
      if (slot_q == SLOT_W'(GPL - 1)) begin
        push_vld_d   = 1'b1;
        push_line_d  = asm_d;
        push_words_d = LWW'(WPL);
        slot_d       = '0;
      end else begin
        slot_d = slot_q + SLOT_W'(1);
      end
    end else if (flush_pend_d) begin
      flush_pend_d = 1'b0;
      if (slot_q != '0) begin
        push_vld_d  = 1'b1;
        push_line_d = asm_q;
        // Unfilled slots may hold stale data from before a reset; zero them.
        for (int s = 0; s < GPL; s++) begin
          if (s >= int'(slot_q)) begin
            push_line_d[LINE_WIDTH-1 - s*GRP_W -: GRP_W] = '0;
          end
        end
        push_words_d = LWW'(int'(slot_q) * FMA_COUNT);
        slot_d       = '0;
      end
    end
    // Sticky errors: a new error on the clearing cycle still registers.
    collision_d = clear_errors_in ? 1'b0 : collision_q;
    if (|clash) begin
      collision_d = 1'b1;
    end
    overflow_d = clear_errors_in ? 1'b0 : overflow_q;
    if (fifo_drop) begin
      overflow_d = 1'b1;
    end
  end

  // Control state, asynchronously cleared; partial groups and lines are discarded.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hold_q       <= '0;
      slot_q       <= '0;
      flush_pend_q <= 1'b0;
      push_vld_q   <= 1'b0;
      collision_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      slot_q       <= slot_d;
      flush_pend_q <= flush_pend_d;
      push_vld_q   <= push_vld_d;
      collision_q  <= collision_d;
      overflow_q   <= overflow_d;
    end
  end

  // Data path registers; qualified by the control state above.
  always_ff @(posedge clk_in) begin
    hold_data_q  <= hold_data_d;
    asm_q        <= asm_d;
    push_line_q  <= push_line_d;
    push_words_q <= push_words_d;
  end

  line_fifo #(
    .WIDTH (LWW + LINE_WIDTH),
    .DEPTH (DEPTH)
  ) u_line_fifo (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .wr_valid_in  (push_vld_q),
    .wr_data_in   ({push_words_q, push_line_q}),
    .wr_ready_out (fma_ready_out),
    .wr_drop_out  (fifo_drop),
    .rd_valid_out (line_valid_out),
    .rd_data_out  (fifo_head),
    .rd_ready_in  (line_ready_in),
    .count_out    (count_out)
  );

  assign line_out       = fifo_head[LINE_WIDTH-1:0];
  assign line_words_out = fifo_head[LWW+LINE_WIDTH-1 -: LWW];
  assign overflow_out   = overflow_q;
  assign collision_out  = collision_q;

endmodule

// File: tb/tb_fma_line_packer.sv
// Directed bench for fma_line_packer at FMA_COUNT=2, WORD_WIDTH=16,
// LINE_WIDTH=96, DEPTH=4 with hand-computed expected lines.
module tb_fma_line_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] fma_out_in = '0;
  logic [1:0]  fma_valid_in = '0;
  logic        flush_in = 1'b0;
  logic        clear_errors_in = 1'b0;
  logic [95:0] line_out;
  logic [3:0]  line_words_out;
  logic        line_valid_out;
  logic        line_ready_in = 1'b0;
  logic        fma_ready_out;
  logic [2:0]  count_out;
  logic        overflow_out;
  logic        collision_out;

  int n_vec = 0;
  int n_err = 0;

  fma_line_packer #(
    .FMA_COUNT(2), .WORD_WIDTH(16), .LINE_WIDTH(96), .DEPTH(4)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .fma_out_in      (fma_out_in),
    .fma_valid_in    (fma_valid_in),
    .flush_in        (flush_in),
    .clear_errors_in (clear_errors_in),
    .line_out        (line_out),
    .line_words_out  (line_words_out),
    .line_valid_out  (line_valid_out),
    .line_ready_in   (line_ready_in),
    .fma_ready_out   (fma_ready_out),
    .count_out       (count_out),
    .overflow_out    (overflow_out),
    .collision_out   (collision_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic grp(input logic [15:0] a, input logic [15:0] b);
    fma_out_in   = {a, b};
    fma_valid_in = 2'b11;
    step();
    fma_valid_in = 2'b00;
  endtask

  task automatic lane(input bit lane0, input logic [15:0] w);
    fma_out_in   = lane0 ? {w, 16'h0000} : {16'h0000, w};
    fma_valid_in = lane0 ? 2'b10 : 2'b01;
    step();
    fma_valid_in = 2'b00;
  endtask

  task automatic flush();
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
  endtask

  task automatic pop();
    line_ready_in = 1'b1;
    step();
    line_ready_in = 1'b0;
  endtask

  function automatic logic [15:0] wd(input int k, input int n);
    return 16'(k * 256 + n);
  endfunction

  function automatic logic [95:0] mk_line(input int k);
    return {wd(k, 1), wd(k, 2), wd(k, 3), wd(k, 4), wd(k, 5), wd(k, 6)};
  endfunction

  task automatic fill_line(input int k);
    for (int j = 0; j < 3; j++) grp(wd(k, 2*j + 1), wd(k, 2*j + 2));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"},    128'(line_valid_out), 128'(0));
    chk({tag, "_line"},     128'(line_out),       128'(0));
    chk({tag, "_words"},    128'(line_words_out), 128'(0));
    chk({tag, "_count"},    128'(count_out),      128'(0));
    chk({tag, "_ready"},    128'(fma_ready_out),  128'(1));
    chk({tag, "_overflow"}, 128'(overflow_out),   128'(0));
    chk({tag, "_collision"},128'(collision_out),  128'(0));
  endtask

  initial begin
    idle(2);
    chk_reset_state("rst0");
    rst = 1'b0;
    idle(1);

    // Three full groups make one line, visible one cycle after the last capture.
    grp(16'h0001, 16'h0002);
    grp(16'h0003, 16'h0004);
    grp(16'h0005, 16'h0006);
    chk("full_lat_early", 128'(line_valid_out), 128'(0));
    step();
    chk("full_valid", 128'(line_valid_out), 128'(1));
    chk("full_line",  128'(line_out), 128'(96'h0001_0002_0003_0004_0005_0006));
    chk("full_words", 128'(line_words_out), 128'(6));
    chk("full_count", 128'(count_out), 128'(1));
    idle(2);
    chk("full_hold",  128'(line_out), 128'(96'h0001_0002_0003_0004_0005_0006));
    pop();
    chk("full_popped", 128'(line_valid_out), 128'(0));

    // Lanes arriving on different cycles still form one group.
    lane(1'b1, 16'hAAAA);
    idle(2);
    lane(1'b0, 16'hBBBB);
    flush();
    step();
    chk("split_line",  128'(line_out), 128'(96'hAAAA_BBBB_0000_0000_0000_0000));
    chk("split_words", 128'(line_words_out), 128'(2));
    chk("split_coll",  128'(collision_out), 128'(0));
    pop();

    // A repeated lane-0 word is dropped and flags a sticky collision.
    lane(1'b1, 16'h1111);
    lane(1'b1, 16'h2222);
    chk("coll_set", 128'(collision_out), 128'(1));
    lane(1'b0, 16'h3333);
    flush();
    step();
    chk("coll_line",   128'(line_out), 128'(96'h1111_3333_0000_0000_0000_0000));
    chk("coll_sticky", 128'(collision_out), 128'(1));
    pop();
    clear_errors_in = 1'b1;
    step();
    clear_errors_in = 1'b0;
    chk("coll_clear", 128'(collision_out), 128'(0));

    // Flush of a single group pads with zeros.
    grp(16'h0011, 16'h0022);
    flush();
    step();
    chk("flush_valid", 128'(line_valid_out), 128'(1));
    chk("flush_line",  128'(line_out), 128'(96'h0011_0022_0000_0000_0000_0000));
    chk("flush_words", 128'(line_words_out), 128'(2));
    pop();

    // Flush with nothing assembled is ignored.
    flush();
    idle(2);
    chk("flush_empty", 128'(line_valid_out), 128'(0));

    // A group completing with a flush wins; the flush lands the next cycle.
    grp(16'h0101, 16'h0202);
    flush_in = 1'b1;
    grp(16'h0303, 16'h0404);
    flush_in = 1'b0;
    idle(2);
    chk("prec_line",  128'(line_out), 128'(96'h0101_0202_0303_0404_0000_0000));
    chk("prec_words", 128'(line_words_out), 128'(4));
    pop();

    // Five lines into a four-deep queue with no consumer.
    for (int k = 1; k <= 5; k++) fill_line(k);
    idle(2);
    chk("ovf_count", 128'(count_out), 128'(4));
    chk("ovf_ready", 128'(fma_ready_out), 128'(0));
    chk("ovf_flag",  128'(overflow_out), 128'(1));
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ovf_head%0d", k), 128'(line_out), 128'(mk_line(k)));
      pop();
    end
    chk("ovf_drained", 128'(line_valid_out), 128'(0));
    clear_errors_in = 1'b1;
    step();
    clear_errors_in = 1'b0;
    chk("ovf_clear", 128'(overflow_out), 128'(0));

    // Push coinciding with a pop at full depth is accepted without overflow.
    for (int k = 1; k <= 5; k++) fill_line(k);
    chk("pp_full", 128'(count_out), 128'(4));
    line_ready_in = 1'b1;
    step();
    line_ready_in = 1'b0;
    chk("pp_count", 128'(count_out), 128'(4));
    chk("pp_ovf",   128'(overflow_out), 128'(0));
    for (int k = 2; k <= 5; k++) begin
      chk($sformatf("pp_head%0d", k), 128'(line_out), 128'(mk_line(k)));
      pop();
    end

    // Reset mid-operation discards queued and partially assembled data.
    fill_line(6);
    grp(wd(8, 1), wd(8, 2));
    grp(wd(8, 3), wd(8, 4));
    lane(1'b1, 16'hDEAD);
    rst = 1'b1;
    #1;
    chk_reset_state("rst_mid");
    step();
    rst = 1'b0;
    step();
    fill_line(7);
    step();
    chk("rst_fresh_line",  128'(line_out), 128'(mk_line(7)));
    chk("rst_fresh_words", 128'(line_words_out), 128'(6));
    chk("rst_fresh_count", 128'(count_out), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
